alu_result_buffer: RTL
======================

Name: alu_result_buffer

Overview:
- Downstream stage of the combinational addition submodule. Captures its result/status pair into a small FIFO with a valid/ready handshake toward the consumer (register file / display controller).
- Sanitises results flagged as errors and maintains a sticky error flag plus a saturating error counter for the top-level status display.

Parameters:
- K, 8, result width in bits; matches the adder's result width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- CW, 8, error counter width.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream presents a result this cycle.
- i_result  input  K  adder result; may be X when status is non-zero.
- i_status  input  4  adder status; 4'b0000 = OK, 4'b1001 = overflow, any non-zero value = error.
- o_ready  output  1  buffer can accept; equals not-full.
- o_valid  output  1  head entry available.
- o_result  output  K  head entry result.
- o_status  output  4  head entry status.
- i_ready  input  1  consumer accepts the head entry this cycle.
- i_clr_err  input  1  clears the sticky flag and the counter.
- o_err_sticky  output  1  set on any accepted error entry.
- o_err_count  output  CW  number of accepted error entries, saturating.
- o_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, i_rst=1): pointers=0, o_count=0, o_valid=0, o_ready=1, o_result=0, o_status=0, o_err_sticky=0, o_err_count=0. Storage contents are don't-care.
- Push: occurs when i_valid && o_ready. The entry stored is {i_status, i_status!=0 ? 0 : i_result}. An X result on an error entry must never reach storage.
- Pop: occurs when o_valid && i_ready. The head pointer advances.
- o_ready and o_valid are derived from registered occupancy only. There is no combinational path from i_ready to o_ready, and none from i_valid to o_valid.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
- o_result and o_status are driven from the head entry. When empty they read 0, not stale data.
- Simultaneous push and pop at 0<count<DEPTH: count is unchanged and both pointers advance.
- Full (count==DEPTH): o_ready=0 and pushes are ignored. A pop in the same cycle does not enable a push; the push is accepted next cycle.
- Empty (count==0): o_valid=0 and i_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter.
- Error tracking is counted on accepted pushes only, not on pops.
  - A pushed entry with non-zero status sets o_err_sticky and increments o_err_count.
  - o_err_count saturates at 2^CW-1 and never wraps.
  - i_clr_err alone: sticky=0, count=0 on the next edge.
  - i_clr_err together with an accepted error push: sticky=1, count=1 (the new event survives the clear).
- State machine (occupancy class, drives o_valid/o_ready):
  - EMPTY -> PARTIAL on push without pop.
  - PARTIAL -> FULL when the push-only transition reaches DEPTH.
  - PARTIAL -> EMPTY when the pop-only transition reaches 0.
  - FULL -> PARTIAL on pop.
  - Push plus pop in PARTIAL stays in PARTIAL.
  - The state is derived from o_count, not held as a separate register.
- Reset mid-operation: all entries are discarded immediately (async), the outputs take their reset values, and no pending pop or push completes.
- i_valid with X on i_result and status 0 is an upstream error. A bench assertion flags it.

Decomposition:
- Shared package alu_pkg: status constants ST_OK=4'b0000, ST_OVF=4'b1001; default K; typedef for the stored entry struct {status[3:0], result[K-1:0]}.
- One sub-module, alu_err_tracker: owns the sticky flag, the saturating counter and the clear priority.
- FIFO storage and pointers stay inline in alu_result_buffer.

Test Plan:
- Reset, then push {0000, 8'h25} with i_ready=0 -> o_valid=1 next cycle, o_result=8'h25, o_count=1; an i_ready pulse -> o_valid=0, o_result=0.
- Push 4 entries (8'h01..8'h04) with i_ready=0 -> o_ready=0 after the 4th; a 5th push of 8'h05 is ignored; pop all -> outputs 01,02,03,04 in order, then empty.
- Continuous i_valid=1 and i_ready=1 for 10 cycles with payloads 0..9 at count=1 -> count stays 1, outputs appear in order with 1-cycle latency, pointers wrap correctly.
- Push {1001, X} -> stored/output entry is {1001, 8'h00}, o_err_sticky=1, o_err_count=1.
- CW=2: push 5 overflow entries -> o_err_count=3 (saturated). i_clr_err asserted with a 6th error push -> count=1, sticky=1.
- Fill with 3 entries, assert i_rst mid-cycle -> o_valid=0, o_ready=1, o_count=0, o_err_count=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: status codes, default widths,
// the stored entry layout and the buffer occupancy classes.
package alu_pkg;

    localparam int K_DEFAULT = 8;

    localparam logic [3:0] ST_OK  = 4'b0000;
    localparam logic [3:0] ST_OVF = 4'b1001;

    typedef struct packed {
        logic [3:0]           status;
        logic [K_DEFAULT-1:0] result;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

endpackage

// File: rtl/alu_err_tracker.sv
// Sticky error flag and saturating error counter. A new error event always
// wins over a clear in the same cycle.
module alu_err_tracker #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          err_event,
    input  logic          clr,
    output logic          sticky,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= 1'b0;
            count  <= '0;
        end else if (err_event) begin
            sticky <= 1'b1;
            if (clr) begin
                count <= CW'(1);
            end else if (count != CNT_MAX) begin
                count <= count + CW'(1);
            end
        end else if (clr) begin
            sticky <= 1'b0;
            count  <= '0;
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Small FIFO behind the adder: sanitises error results, hands entries to the
// consumer over valid/ready and feeds the error tracker.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int K     = K_DEFAULT,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [K-1:0]             i_result,
    input  logic [3:0]               i_status,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [K-1:0]             o_result,
    output logic [3:0]               o_status,
    input  logic                     i_ready,
    input  logic                     i_clr_err,
    output logic                     o_err_sticky,
    output logic [CW-1:0]            o_err_count,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    typedef struct packed {
        logic [3:0]   status;
        logic [K-1:0] result;
    } slot_t;

    slot_t         mem [DEPTH];
    slot_t         head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count_q;
    logic [NW-1:0] count_next;
    occ_t          occ;
    logic          push;
    logic          pop;
    logic          err_event;

    assign push      = i_valid && o_ready;
    assign pop       = o_valid && i_ready;
    assign err_event = push && (i_status != ST_OK);
    assign o_count   = count_q;

    // Occupancy counter is the only state; the occupancy class is decoded from it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Error results are zeroed on the way in so an X never lands in storage.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr].status <= i_status;
            mem[wr_ptr].result <= (i_status != ST_OK) ? {K{1'b0}} : i_result;
        end
    end

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + NW'(1);
            2'b01:   count_next = count_q - NW'(1);
            default: count_next = count_q;
        endcase
    end

    always_comb begin
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == NW'(DEPTH)) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_PARTIAL;
        end
    end

    always_comb begin
        head     = mem[rd_ptr];
        o_valid  = (occ != OCC_EMPTY);
        o_ready  = (occ != OCC_FULL);
        o_result = (occ != OCC_EMPTY) ? head.result : {K{1'b0}};
        o_status = (occ != OCC_EMPTY) ? head.status : 4'b0000;
    end

    alu_err_tracker #(
        .CW(CW)
    ) u_err (
        .clk       (i_clk),
        .rst       (i_rst),
        .err_event (err_event),
        .clr       (i_clr_err),
        .sticky    (o_err_sticky),
        .count     (o_err_count)
    );

endmodule
